// File: rtl/adder_stim_checker.sv
// LFSR stimulus generator and DUT-vs-golden compare stage for the adder lab.
// Build option: define ADDER_CHK_CORNER_EN to prepend four fixed corner vectors to every run.
module adder_stim_checker #(
  parameter int unsigned SIZE    = 32,
  parameter int unsigned DUT_LAT = 0,
  parameter logic [31:0] SEED_A  = 32'h1,
  parameter logic [31:0] SEED_B  = 32'hACE1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [15:0]     num_vectors,
  output logic [SIZE-1:0] A,
  output logic [SIZE-1:0] B,
  output logic            cin,
  input  logic [SIZE-1:0] dut_sum,
  input  logic            dut_cout,
  input  logic [SIZE-1:0] ref_sum,
  input  logic            ref_cout,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     err_count,
  output logic [15:0]     vec_count,
  output logic [SIZE-1:0] fail_a,
  output logic [SIZE-1:0] fail_b,
  output logic            fail_cin,
  output logic [SIZE:0]   fail_dut
);

`ifdef ADDER_CHK_CORNER_EN
  localparam int unsigned NUM_CORNER = 4;
`else
  localparam int unsigned NUM_CORNER = 0;
`endif
  localparam int unsigned RW = 17;
  localparam int unsigned SW = SIZE + 1;
  localparam int unsigned OW = 2 * SIZE + 1;
  localparam int unsigned EW = 1 + SW + OW;
  localparam logic [31:0]     POLY = 32'h80200003;
  localparam logic [SIZE-1:0] ONES = {SIZE{1'b1}};
  localparam logic [SIZE-1:0] MSB  = SIZE'(1) << (SIZE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  function automatic logic [OW-1:0] map_vec(input logic [31:0] la, input logic [31:0] lb);
    return {la[SIZE-1:0], lb[SIZE-1:0], la[31] ^ lb[31]};
  endfunction

  function automatic logic [OW-1:0] corner_vec(input logic [1:0] i);
    unique case (i)
      2'd0:    return {SIZE'(0), SIZE'(0), 1'b0};
      2'd1:    return {ONES, ONES, 1'b1};
      2'd2:    return {ONES, SIZE'(0), 1'b1};
      default: return {MSB, MSB, 1'b0};
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [31:0]     lfsr_a_q, lfsr_a_d, lfsr_b_q, lfsr_b_d;
  logic [OW-1:0]   ops_q, ops_d, fail_ops_q, fail_ops_d;
  logic [SW-1:0]   fail_dut_q, fail_dut_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [2:0]      idx_q, idx_d;
  logic [1:0]      drain_q, drain_d;
  logic [15:0]     err_q, err_d, vec_q, vec_d;
  logic            busy_q, busy_d, done_q, done_d, pass_q, pass_d;

  logic            issue;
  logic [EW-1:0]   push_entry, tap;
  logic            tap_vld;
  logic [SW-1:0]   tap_res;
  logic [OW-1:0]   tap_ops;

  // The vector currently on A/B/cin is issued (and its golden result captured) at this edge.
  assign issue      = (state_q == RUN) && (rem_q != '0);
  assign push_entry = {issue, ref_cout, ref_sum, ops_q};

  if (DUT_LAT == 0) begin : g_bypass
    assign tap = push_entry;
  end else begin : g_dline
    logic [EW-1:0] dl_q [DUT_LAT];
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < int'(DUT_LAT); i++) dl_q[i] <= '0;
      end else begin
        dl_q[0] <= push_entry;
        for (int i = 1; i < int'(DUT_LAT); i++) dl_q[i] <= dl_q[i-1];
      end
    end
    assign tap = dl_q[DUT_LAT-1];
  end

  assign tap_vld = tap[EW-1];
  assign tap_res = tap[EW-2 -: SW];
  assign tap_ops = tap[OW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_a_q   <= SEED_A;
      lfsr_b_q   <= SEED_B;
      ops_q      <= '0;
      fail_ops_q <= '0;
      fail_dut_q <= '0;
      rem_q      <= '0;
      idx_q      <= '0;
      drain_q    <= '0;
      err_q      <= '0;
      vec_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_a_q   <= lfsr_a_d;
      lfsr_b_q   <= lfsr_b_d;
      ops_q      <= ops_d;
      fail_ops_q <= fail_ops_d;
      fail_dut_q <= fail_dut_d;
      rem_q      <= rem_d;
      idx_q      <= idx_d;
      drain_q    <= drain_d;
      err_q      <= err_d;
      vec_q      <= vec_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lfsr_a_d   = lfsr_a_q;
    lfsr_b_d   = lfsr_b_q;
    ops_d      = ops_q;
    fail_ops_d = fail_ops_q;
    fail_dut_d = fail_dut_q;
    rem_d      = rem_q;
    idx_d      = idx_q;
    drain_d    = drain_q;
    err_d      = err_q;
    vec_d      = vec_q;

    // Compare the delayed golden result against the DUT output of the same vector.
    if (tap_vld) begin
      vec_d = vec_q + 16'd1;
      if (tap_res != {dut_cout, dut_sum}) begin
        if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        if (err_q == 16'd0) begin
          fail_ops_d = tap_ops;
          fail_dut_d = {dut_cout, dut_sum};
        end
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          lfsr_a_d   = SEED_A;
          lfsr_b_d   = SEED_B;
          rem_d      = RW'(num_vectors) + RW'(NUM_CORNER);
          idx_d      = 3'd0;
          ops_d      = (NUM_CORNER != 0) ? corner_vec(2'd0) : map_vec(SEED_A, SEED_B);
          err_d      = 16'd0;
          vec_d      = 16'd0;
          fail_ops_d = '0;
          fail_dut_d = '0;
        end
      end
      RUN: begin
        if (issue) begin
          rem_d = rem_q - RW'(1);
          // Load the next vector only if one remains; LFSRs hold while corners play.
          if (rem_q > RW'(1)) begin
            if ((NUM_CORNER != 0) && (idx_q < 3'd3)) begin
              idx_d = idx_q + 3'd1;
              ops_d = corner_vec(2'(idx_q + 3'd1));
            end else if ((NUM_CORNER != 0) && (idx_q == 3'd3)) begin
              idx_d = 3'd4;
              ops_d = map_vec(lfsr_a_q, lfsr_b_q);
            end else begin
              lfsr_a_d = lfsr_step(lfsr_a_q);
              lfsr_b_d = lfsr_step(lfsr_b_q);
              ops_d    = map_vec(lfsr_a_d, lfsr_b_d);
            end
          end
        end else if (DUT_LAT == 0) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
          drain_d = 2'(DUT_LAT - 1);
        end
      end
      DRAIN: begin
        if (drain_q == 2'd0) state_d = DONE;
        else                 drain_d = drain_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
    pass_d = done_d && (err_d == 16'd0);
  end

  assign A         = ops_q[OW-1 -: SIZE];
  assign B         = ops_q[SIZE -: SIZE];
  assign cin       = ops_q[0];
  assign fail_a    = fail_ops_q[OW-1 -: SIZE];
  assign fail_b    = fail_ops_q[SIZE -: SIZE];
  assign fail_cin  = fail_ops_q[0];
  assign fail_dut  = fail_dut_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;

endmodule

// File: tb/tb_adder_stim_checker.sv
// Bench for adder_stim_checker: a 32-bit zero-latency instance with an injectable stuck-bit DUT
// and an 8-bit instance driving a 2-stage registered adder; honours ADDER_CHK_CORNER_EN.
`timescale 1ns/1ps
module tb_adder_stim_checker;
`ifdef ADDER_CHK_CORNER_EN
  localparam int NC = 4;
`else
  localparam int NC = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start0, start2, fault0;
  logic [15:0] nv;
  int          n_cmp = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 32-bit, DUT_LAT = 0 instance
  logic [31:0] a0, b0, fa0, fb0;
  logic        cin0, busy0, done0, pass0, fcin0;
  logic [15:0] err0, vec0;
  logic [32:0] fdut0, gold0, dut0;
  assign gold0 = {1'b0, a0} + {1'b0, b0} + 33'(cin0);
  assign dut0  = fault0 ? (gold0 & ~33'h8) : gold0;

  adder_stim_checker #(.SIZE(32), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .num_vectors(nv),
    .A(a0), .B(b0), .cin(cin0),
    .dut_sum(dut0[31:0]), .dut_cout(dut0[32]), .ref_sum(gold0[31:0]), .ref_cout(gold0[32]),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .vec_count(vec0),
    .fail_a(fa0), .fail_b(fb0), .fail_cin(fcin0), .fail_dut(fdut0));

  // 8-bit, DUT_LAT = 2 instance with a two-stage registered golden adder as DUT
  logic [7:0]  a2, b2, fa2, fb2;
  logic        cin2, busy2, done2, pass2, fcin2;
  logic [15:0] err2, vec2;
  logic [8:0]  fdut2, gold2, p1, p2;
  assign gold2 = {1'b0, a2} + {1'b0, b2} + 9'(cin2);
  always @(posedge clk) begin
    p1 <= gold2;
    p2 <= p1;
  end

  adder_stim_checker #(.SIZE(8), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .num_vectors(nv),
    .A(a2), .B(b2), .cin(cin2),
    .dut_sum(p2[7:0]), .dut_cout(p2[8]), .ref_sum(gold2[7:0]), .ref_cout(gold2[8]),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .vec_count(vec2),
    .fail_a(fa2), .fail_b(fb2), .fail_cin(fcin2), .fail_dut(fdut2));

  // Reference vector list and observed vector list
  logic [31:0] ma[$], mb[$], oa[$], ob[$];
  logic        mc[$], oc[$];

  function automatic logic [31:0] step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  task automatic build_model(input int size, input int n);
    logic [31:0] la, lb, mask, msb;
    la   = 32'h1;
    lb   = 32'hACE1;
    mask = (size == 32) ? 32'hFFFF_FFFF : ((32'h1 << size) - 32'h1);
    msb  = 32'h1 << (size - 1);
    ma.delete(); mb.delete(); mc.delete();
    if (NC != 0) begin
      ma.push_back(32'h0); mb.push_back(32'h0); mc.push_back(1'b0);
      ma.push_back(mask);  mb.push_back(mask);  mc.push_back(1'b1);
      ma.push_back(mask);  mb.push_back(32'h0); mc.push_back(1'b1);
      ma.push_back(msb);   mb.push_back(msb);   mc.push_back(1'b0);
    end
    for (int k = 0; k < n; k++) begin
      ma.push_back(la & mask);
      mb.push_back(lb & mask);
      mc.push_back(la[31] ^ lb[31]);
      la = step(la);
      lb = step(lb);
    end
  endtask

  function automatic int seq_diffs();
    int d = 0;
    if (oa.size() != ma.size()) return 9999;
    foreach (ma[k]) if (oa[k] !== ma[k] || ob[k] !== mb[k] || oc[k] !== mc[k]) d++;
    return d;
  endfunction

  // Pulse start, record the issued vectors, and measure edges from the start edge to done.
  task automatic go(input bit sel, input int n, output int elapsed);
    int t0;
    int budget;
    budget = n + NC + 12;
    oa.delete(); ob.delete(); oc.delete();
    nv = 16'(n);
    if (sel) start2 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start2 = 1'b0;
    t0 = cyc;
    elapsed = -1;
    for (int j = 0; j < budget; j++) begin
      if (j < n + NC) begin
        oa.push_back(sel ? {24'd0, a2} : a0);
        ob.push_back(sel ? {24'd0, b2} : b0);
        oc.push_back(sel ? cin2 : cin0);
      end
      if ((sel ? done2 : done0) === 1'b1) begin
        elapsed = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    n_cmp++;
    if ({a0, b0, cin0} !== 65'd0) begin
      n_fail++; $display("FAIL reset_ops: got %h want 0", {a0, b0, cin0});
    end
    n_cmp++;
    if ({busy0, done0, pass0, busy2, done2, pass2} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000000", {busy0, done0, pass0, busy2, done2, pass2});
    end
    n_cmp++;
    if ({err0, vec0, err2, vec2} !== 64'd0) begin
      n_fail++; $display("FAIL reset_counts: got %h want 0", {err0, vec0, err2, vec2});
    end
    n_cmp++;
    if ({fa0, fb0, fcin0, fdut0} !== 98'd0) begin
      n_fail++; $display("FAIL reset_fail_regs: got %h want 0", {fa0, fb0, fcin0, fdut0});
    end
    rst = 1'b0;
    tick(1);
  endtask

  task automatic test_golden_lat0();
    int el;
    fault0 = 1'b0;
    go(1'b0, 100, el);
    build_model(32, 100 + NC);
    n_cmp++;
    if (el !== 100 + NC + 1) begin n_fail++; $display("FAIL lat0_done_time: got %0d want %0d", el, 100 + NC + 1); end
    n_cmp++;
    if (seq_diffs() != 0) begin n_fail++; $display("FAIL lat0_vectors: %0d differ want 0", seq_diffs()); end
    n_cmp++;
    if ({pass0, err0, vec0} !== {1'b1, 16'd0, 16'(100 + NC)}) begin
      n_fail++; $display("FAIL lat0_result: pass/err/vec got %b/%0d/%0d want 1/0/%0d", pass0, err0, vec0, 100 + NC);
    end
    tick(3);
    n_cmp++;
    if ({done0, busy0} !== 2'b10) begin n_fail++; $display("FAIL lat0_done_hold: done/busy got %b want 10", {done0, busy0}); end
  endtask

  task automatic test_lat2();
    int el;
    go(1'b1, 50, el);
    build_model(8, 50 + NC);
    n_cmp++;
    if (el !== 50 + NC + 3) begin n_fail++; $display("FAIL lat2_done_time: got %0d want %0d", el, 50 + NC + 3); end
    n_cmp++;
    if (seq_diffs() != 0) begin n_fail++; $display("FAIL lat2_vectors: %0d differ want 0", seq_diffs()); end
    n_cmp++;
    if ({pass2, err2, vec2} !== {1'b1, 16'd0, 16'(50 + NC)}) begin
      n_fail++; $display("FAIL lat2_result: pass/err/vec got %b/%0d/%0d want 1/0/%0d", pass2, err2, vec2, 50 + NC);
    end
  endtask

  task automatic test_stuck_bit3();
    int el, errs, first;
    logic [32:0] s, fd;
    fault0 = 1'b1;
    go(1'b0, 200, el);
    fault0 = 1'b0;
    build_model(32, 200 + NC);
    errs = 0; first = -1; fd = '0;
    foreach (ma[k]) begin
      s = {1'b0, ma[k]} + {1'b0, mb[k]} + 33'(mc[k]);
      if (s[3]) begin
        errs++;
        if (first < 0) begin first = k; fd = s & ~33'h8; end
      end
    end
    n_cmp++;
    if ({pass0, err0, vec0} !== {1'b0, 16'(errs), 16'(200 + NC)} || errs == 0) begin
      n_fail++; $display("FAIL stuck_result: pass/err/vec got %b/%0d/%0d want 0/%0d/%0d", pass0, err0, vec0, errs, 200 + NC);
    end
    n_cmp++;
    if (first < 0 || {fa0, fb0, fcin0} !== {ma[first], mb[first], mc[first]}) begin
      n_fail++; $display("FAIL stuck_fail_ops: got %h/%h/%b want vector %0d", fa0, fb0, fcin0, first);
    end
    n_cmp++;
    if (fdut0 !== fd) begin n_fail++; $display("FAIL stuck_fail_dut: got %h want %h", fdut0, fd); end
  endtask

  task automatic test_zero_vectors();
    int el;
    go(1'b0, 0, el);
    n_cmp++;
    if (el !== NC + 1) begin n_fail++; $display("FAIL zero_lat0_time: got %0d want %0d", el, NC + 1); end
    n_cmp++;
    if ({pass0, err0, vec0, fa0, fdut0} !== {1'b1, 16'd0, 16'(NC), 32'd0, 33'd0}) begin
      n_fail++; $display("FAIL zero_lat0_result: pass/err/vec/fa got %b/%0d/%0d/%h want 1/0/%0d/0", pass0, err0, vec0, fa0, NC);
    end
    go(1'b1, 0, el);
    n_cmp++;
    if (el !== NC + 3 || vec2 !== 16'(NC) || pass2 !== 1'b1) begin
      n_fail++; $display("FAIL zero_lat2: time/vec/pass got %0d/%0d/%b want %0d/%0d/1", el, vec2, pass2, NC + 3, NC);
    end
  endtask

  task automatic test_reset_midrun();
    int el;
    nv = 16'd100;
    start0 = 1'b1;
    tick(1);
    start0 = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(1);
    n_cmp++;
    if ({a0, b0, cin0, busy0, done0, pass0, err0, vec0, fa0, fb0, fcin0, fdut0} !== 198'd0) begin
      n_fail++; $display("FAIL midrun_reset: A=%h B=%h busy=%b vec=%0d err=%0d want all 0", a0, b0, busy0, vec0, err0);
    end
    rst = 1'b0;
    go(1'b0, 30, el);
    build_model(32, 30 + NC);
    n_cmp++;
    if (seq_diffs() != 0 || el !== 30 + NC + 1 || vec0 !== 16'(30 + NC)) begin
      n_fail++; $display("FAIL midrun_restart: diffs/time/vec got %0d/%0d/%0d want 0/%0d/%0d", seq_diffs(), el, vec0, 30 + NC + 1, 30 + NC);
    end
  endtask

  task automatic test_back_to_back();
    int el, n;
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(1, 60));
      go(r[0], n, el);
      build_model(r[0] ? 8 : 32, n + NC);
      n_cmp++;
      if (seq_diffs() != 0 || el !== n + NC + (r[0] ? 3 : 1)) begin
        n_fail++; $display("FAIL b2b_run%0d: n=%0d diffs=%0d time=%0d", r, n, seq_diffs(), el);
      end
      n_cmp++;
      if ((r[0] ? {pass2, vec2} : {pass0, vec0}) !== {1'b1, 16'(n + NC)}) begin
        n_fail++; $display("FAIL b2b_result%0d: pass/vec got %b/%0d want 1/%0d", r, r[0] ? pass2 : pass0, r[0] ? vec2 : vec0, n + NC);
      end
    end
  endtask

`ifdef ADDER_CHK_CORNER_EN
  task automatic test_corner();
    int el;
    logic [16:0] exp_v [4];
    exp_v[0] = {8'h00, 8'h00, 1'b0};
    exp_v[1] = {8'hFF, 8'hFF, 1'b1};
    exp_v[2] = {8'hFF, 8'h00, 1'b1};
    exp_v[3] = {8'h80, 8'h80, 1'b0};
    go(1'b1, 3, el);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (oa.size() < 4 || {oa[k][7:0], ob[k][7:0], oc[k]} !== exp_v[k]) begin
        n_fail++; $display("FAIL corner_vec%0d: want %h", k, exp_v[k]);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start0 = 1'b0; start2 = 1'b0; fault0 = 1'b0; nv = 16'd0;
    test_reset();
    test_golden_lat0();
    test_lat2();
    test_stuck_bit3();
    test_zero_vectors();
    test_reset_midrun();
    test_back_to_back();
`ifdef ADDER_CHK_CORNER_EN
    test_corner();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
